// File: rtl/jtcop_mcu_mbox_if.sv
// Bus bundle between the main CPU MCU window / MCU port glue and jtcop_mcu_mbox.
// Handshake: cpu_cs qualifies a single-cycle access (cpu_rnw/cpu_addr/cpu_dout/dsn valid with it, no stall);
// cpu_din answers the cycle after a read; mcu_rd_*/mcu_wr_* are one-cycle event pulses from the MCU side.
interface jtcop_mcu_mbox_if;
   logic        cpu_cs;
   logic        cpu_rnw;
   logic        cpu_addr;
   logic [15:0] cpu_dout;
   logic [1:0]  dsn;
   logic [15:0] cpu_din;
   logic        irqn;
   logic [15:0] mcu_din;
   logic [5:0]  mcu_sel;
   logic [15:0] mcu_dout;
   logic        mcu_rd_hi;
   logic        mcu_rd_lo;
   logic        mcu_wr_lo;
   logic        mcu_wr_hi;

   modport slave (
      input  cpu_cs, cpu_rnw, cpu_addr, cpu_dout, dsn,
      input  mcu_dout, mcu_rd_hi, mcu_rd_lo, mcu_wr_lo, mcu_wr_hi,
      output cpu_din, irqn, mcu_din, mcu_sel
   );

   modport master (
      output cpu_cs, cpu_rnw, cpu_addr, cpu_dout, dsn,
      output mcu_dout, mcu_rd_hi, mcu_rd_lo, mcu_wr_lo, mcu_wr_hi,
      input  cpu_din, irqn, mcu_din, mcu_sel
   );
endinterface

// File: rtl/jtcop_mcu_mbox.sv
// Main-CPU side mailbox for the i8751 protection MCU: sends a command word,
// strobes the MCU interrupt, follows its byte reads/writes and latches the reply.
module jtcop_mcu_mbox #(
   parameter int SEL_W  = 4,
   parameter int TMO_W  = 16,
   parameter int IRQ_EN = 1
) (
   input  logic                clk,
   input  logic                rst,
   jtcop_mcu_mbox_if.slave     bus,
   output logic [2:0]          dbg_state
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] STROBE  = 3'd1;
   localparam logic [2:0] WAIT_RD = 3'd2;
   localparam logic [2:0] WAIT_WR = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam logic [3:0]       SEL_LAST = 4'(SEL_W - 1);
   // Firing one count early makes the timeout land after exactly 2^TMO_W-1 busy cycles.
   localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   logic [2:0]       state;
   logic [3:0]       sel_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [4:0]       sel_hi;
   logic [15:0]      cmd;
   logic [15:0]      reply;
   logic [15:0]      cpu_din_r;
   logic             irqn_r;
   logic             cmd_pending;
   logic             resp_valid;
   logic             overrun;
   logic             timeout;
   logic             rd_hi_seen;
   logic             rd_lo_seen;
   logic             wr_hi_seen;
   logic             wr_lo_seen;

   logic        cmd_wr;
   logic        sel_wr;
   logic        reply_rd;
   logic        active;
   logic        rd_both;
   logic        wr_both;
   logic        tmo_hit;
   logic [15:0] status;

   assign cmd_wr   = bus.cpu_cs & ~bus.cpu_rnw & ~bus.cpu_addr;
   assign sel_wr   = bus.cpu_cs & ~bus.cpu_rnw &  bus.cpu_addr;
   assign reply_rd = bus.cpu_cs &  bus.cpu_rnw & ~bus.cpu_addr;

   assign active  = (state == STROBE) || (state == WAIT_RD) || (state == WAIT_WR);
   assign rd_both = (rd_hi_seen | bus.mcu_rd_hi) & (rd_lo_seen | bus.mcu_rd_lo);
   assign wr_both = (wr_hi_seen | bus.mcu_wr_hi) & (wr_lo_seen | bus.mcu_wr_lo);
   assign tmo_hit = active && (tmo_cnt == TMO_LAST);

   assign status = {11'd0, timeout, overrun, (state != IDLE), resp_valid, cmd_pending};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sel_cnt     <= '0;
         tmo_cnt     <= '0;
         sel_hi      <= '0;
         cmd         <= '0;
         reply       <= '0;
         cpu_din_r   <= '0;
         irqn_r      <= 1'b1;
         cmd_pending <= 1'b0;
         resp_valid  <= 1'b0;
         overrun     <= 1'b0;
         timeout     <= 1'b0;
         rd_hi_seen  <= 1'b0;
         rd_lo_seen  <= 1'b0;
         wr_hi_seen  <= 1'b0;
         wr_lo_seen  <= 1'b0;
      end else begin
         if (sel_wr && !bus.dsn[0]) sel_hi <= bus.cpu_dout[5:1];
         if (bus.cpu_cs && bus.cpu_rnw) cpu_din_r <= bus.cpu_addr ? status : reply;
         if (reply_rd) begin
            resp_valid <= 1'b0;
            irqn_r     <= 1'b1;
         end
         if (active) tmo_cnt <= tmo_cnt + 1'b1;
         if (cmd_wr && state != IDLE) overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (cmd_wr) begin
                  if (!bus.dsn[1]) cmd[15:8] <= bus.cpu_dout[15:8];
                  if (!bus.dsn[0]) cmd[7:0]  <= bus.cpu_dout[7:0];
                  state       <= STROBE;
                  sel_cnt     <= SEL_LAST;
                  tmo_cnt     <= '0;
                  cmd_pending <= 1'b1;
                  timeout     <= 1'b0;
                  overrun     <= 1'b0;
                  resp_valid  <= 1'b0;
                  irqn_r      <= 1'b1;
                  rd_hi_seen  <= 1'b0;
                  rd_lo_seen  <= 1'b0;
                  wr_hi_seen  <= 1'b0;
                  wr_lo_seen  <= 1'b0;
               end
            end
            STROBE: begin
               if (bus.mcu_rd_hi) rd_hi_seen <= 1'b1;
               if (bus.mcu_rd_lo) rd_lo_seen <= 1'b1;
               if (sel_cnt == 4'd0) state <= WAIT_RD;
               else                 sel_cnt <= sel_cnt - 4'd1;
            end
            WAIT_RD: begin
               if (bus.mcu_rd_hi) rd_hi_seen <= 1'b1;
               if (bus.mcu_rd_lo) rd_lo_seen <= 1'b1;
               if (rd_both) begin
                  cmd_pending <= 1'b0;
                  state       <= WAIT_WR;
               end
            end
            WAIT_WR: begin
               if (bus.mcu_wr_hi) wr_hi_seen <= 1'b1;
               if (bus.mcu_wr_lo) wr_lo_seen <= 1'b1;
               if (wr_both) begin
                  reply <= bus.mcu_dout;
                  state <= DONE;
               end
            end
            DONE: begin
               // Placed after the reply-read clear so a coinciding read cannot swallow the reply.
               resp_valid <= 1'b1;
               irqn_r     <= (IRQ_EN == 0);
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (tmo_hit) begin
            timeout     <= 1'b1;
            cmd_pending <= 1'b0;
            state       <= IDLE;
         end
      end
   end

   assign bus.mcu_din = cmd;
   assign bus.mcu_sel = {sel_hi, (state == STROBE)};
   assign bus.cpu_din = cpu_din_r;
   assign bus.irqn    = irqn_r;
   assign dbg_state   = state;

endmodule
